fault_pattern_sequencer: RTL and testbench
==========================================

Name: fault_pattern_sequencer

Overview:
- Synthesizable pattern controller that drives a combinational module-under-test (c6288-class 16x16 multiplier: 32 inputs, 32 outputs) in fault-simulation and fault-collapsing runs.
- Generates an input pattern stream in either incrementing-counter mode (exhaustive sweep) or Galois-LFSR mode (pseudo-random).
- Holds each pattern for a programmable settle interval, then samples the MUT outputs and compacts them into a MISR signature.
- Reports the signature and pattern count with a start/busy/done handshake.

Parameters:
- IN_W, 32, MUT input width / pattern width
- OUT_W, 32, MUT output width / MISR width
- SETTLE_W, 16, width of the settle-interval counter
- LFSR_POLY, 32'h80200003, Galois right-shift feedback mask (IN_W bits)
- MISR_POLY, 32'h04C11DB7, MISR left-shift feedback mask (OUT_W bits)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  run request; sampled only in IDLE
- mode  in  1  0 = counter, 1 = LFSR; latched at start
- seed  in  IN_W  first pattern; latched at start
- num_patterns  in  IN_W+1  number of patterns to apply (2^IN_W allowed); latched at start
- settle_cycles  in  SETTLE_W  extra hold cycles per pattern; latched at start
- mut_in  out  IN_W  pattern driven to the MUT
- mut_out  in  OUT_W  MUT response
- sample_valid  out  1  one-cycle pulse in each SAMPLE cycle
- busy  out  1  high in SETTLE and SAMPLE
- done  out  1  one-cycle pulse in the DONE state
- signature  out  OUT_W  MISR contents; held after completion
- pattern_cnt  out  IN_W+1  number of patterns sampled so far

Behaviour:
- Reset: state IDLE; mut_in, signature, pattern_cnt = 0; sample_valid, busy, done = 0. Reset at any point aborts the run immediately, with no done pulse.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - With start=1: latch mode, num_patterns and settle_cycles; clear signature and pattern_cnt.
  - If num_patterns==0, go to DONE. Otherwise load mut_in (see LFSR zero-seed rule), load timer=settle_cycles, go to SETTLE.
  - With start=0: stay; outputs hold.
- SETTLE: if timer==0 go to SAMPLE, else decrement timer. SETTLE therefore lasts settle_cycles+1 cycles.
- SAMPLE (1 cycle):
  - sample_valid=1.
  - signature <= {signature[OUT_W-2:0],1'b0} ^ (signature[OUT_W-1] ? MISR_POLY : 0) ^ mut_out.
  - pattern_cnt <= pattern_cnt+1.
  - If pattern_cnt+1 == num_patterns, go to DONE with mut_in held. Otherwise advance mut_in, reload timer, go to SETTLE.
- Pattern advance:
  - Counter mode: mut_in+1, modulo 2^IN_W (FFFFFFFF wraps to 0).
  - LFSR mode: (mut_in>>1) ^ (mut_in[0] ? LFSR_POLY : 0).
- LFSR zero seed: in LFSR mode a seed of 0 is replaced by 1. Counter mode accepts 0.
- DONE (1 cycle): done=1, busy=0, then go to IDLE. signature, pattern_cnt and mut_in hold until the next accepted start.
- Timing: per-pattern period = settle_cycles+2 cycles. done is asserted (settle_cycles+2)*num_patterns+1 cycles after the edge that accepts start.
- start is ignored in SETTLE, SAMPLE and DONE.
- Configuration inputs may change freely after they are latched.
- pattern_cnt counter has IN_W+1 bits, so an exhaustive 2^32 run ends with pattern_cnt = 33'h1_0000_0000.

Test Plan:
- Counter loopback: mut_out=mut_in, mode=0, seed=0, num=3, settle=2, start at cycle 0 -> mut_in 0,1,2 held 4 cycles each; sample_valid at cycles 4, 8, 12; done at cycle 13; pattern_cnt=3; signature=0 (0 -> 1 -> 0).
- LFSR zero seed: mode=1, seed=0, num=3, settle=0 -> mut_in sequence 00000001, 80200003, C0300002; done at cycle 7.
- Wrap and no-settle: mode=0, seed=FFFFFFFF, num=2, settle=0, mut_out=32'h1 -> patterns FFFFFFFF, 00000000; signature=32'h00000003; pattern_cnt=2.
- Zero patterns: num=0 -> done one cycle after start; busy never high; sample_valid never high; signature=0; pattern_cnt=0.
- Start while busy: second start pulse mid-run with different seed -> ignored; first run completes unchanged; a start after done reruns with the new config and clears the signature first.
- Reset mid-run: rst asserted during the 2nd SETTLE of a num=5 run -> next cycle state IDLE, all outputs 0, no done pulse; a subsequent start runs normally.

Source files
------------

// File: rtl/fault_pattern_sequencer.sv
// Pattern controller for fault-simulation runs: drives counter or LFSR patterns into a
// combinational MUT, holds each for a settle interval, and compacts the responses in a MISR.
module fault_pattern_sequencer #(
    parameter int               IN_W      = 32,
    parameter int               OUT_W     = 32,
    parameter int               SETTLE_W  = 16,
    parameter logic [IN_W-1:0]  LFSR_POLY = 32'h80200003,
    parameter logic [OUT_W-1:0] MISR_POLY = 32'h04C11DB7
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic                i_mode,
    input  logic [IN_W-1:0]     i_seed,
    input  logic [IN_W:0]       i_num_patterns,
    input  logic [SETTLE_W-1:0] i_settle_cycles,
    output logic [IN_W-1:0]     o_mut_in,
    input  logic [OUT_W-1:0]    i_mut_out,
    output logic                o_sample_valid,
    output logic                o_busy,
    output logic                o_done,
    output logic [OUT_W-1:0]    o_signature,
    output logic [IN_W:0]       o_pattern_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t              r_state;
    logic                r_mode;
    logic [IN_W:0]       r_num;
    logic [SETTLE_W-1:0] r_settle;
    logic [SETTLE_W-1:0] r_timer;
    logic [IN_W-1:0]     r_mut_in;
    logic [OUT_W-1:0]    r_sig;
    logic [IN_W:0]       r_cnt;
    logic                r_sample_valid;
    logic                r_busy;
    logic                r_done;

    logic [IN_W-1:0]     w_next_pat;
    logic [IN_W-1:0]     w_seed_eff;
    logic [OUT_W-1:0]    w_misr_next;
    logic [IN_W:0]       w_cnt_inc;

    always_comb begin
        w_next_pat = r_mut_in + IN_W'(1);
        if (r_mode)
            w_next_pat = (r_mut_in >> 1) ^ (r_mut_in[0] ? LFSR_POLY : '0);
        // An all-zero LFSR state would lock up, so a zero seed starts at 1 instead.
        w_seed_eff  = (i_mode && i_seed == '0) ? IN_W'(1) : i_seed;
        w_misr_next = {r_sig[OUT_W-2:0], 1'b0} ^ (r_sig[OUT_W-1] ? MISR_POLY : '0) ^ i_mut_out;
        w_cnt_inc   = r_cnt + (IN_W+1)'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_mode         <= 1'b0;
            r_num          <= '0;
            r_settle       <= '0;
            r_timer        <= '0;
            r_mut_in       <= '0;
            r_sig          <= '0;
            r_cnt          <= '0;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode   <= i_mode;
                        r_num    <= i_num_patterns;
                        r_settle <= i_settle_cycles;
                        r_sig    <= '0;
                        r_cnt    <= '0;
                        if (i_num_patterns == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_mut_in <= w_seed_eff;
                            r_timer  <= i_settle_cycles;
                            r_busy   <= 1'b1;
                            r_state  <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_timer == '0) begin
                        r_state        <= S_SAMPLE;
                        r_sample_valid <= 1'b1;
                    end else begin
                        r_timer <= r_timer - SETTLE_W'(1);
                    end
                end
                S_SAMPLE: begin
                    r_sig <= w_misr_next;
                    r_cnt <= w_cnt_inc;
                    if (w_cnt_inc == r_num) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_mut_in <= w_next_pat;
                        r_timer  <= r_settle;
                        r_state  <= S_SETTLE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_mut_in       = r_mut_in;
    assign o_sample_valid = r_sample_valid;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_signature    = r_sig;
    assign o_pattern_cnt  = r_cnt;

endmodule

// File: tb/tb_fault_pattern_sequencer.sv
// Randomized bench for fault_pattern_sequencer; expected per-cycle outputs come from a
// pattern list and signature fold built up front for each run.
module tb_fault_pattern_sequencer;

    localparam logic [31:0] LFSR = 32'h80200003;
    localparam logic [31:0] MISR = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [31:0] seed;
    logic [32:0] num;
    logic [15:0] settle;
    logic [31:0] mut_in;
    logic [31:0] mut_out;
    logic        sample_valid;
    logic        busy;
    logic        done;
    logic [31:0] signature;
    logic [32:0] pattern_cnt;

    int          checks = 0;
    int          errors = 0;
    int          mut_sel = 0;
    logic [31:0] last_mut = '0;
    logic [31:0] pats[$];
    logic [31:0] sigs[$];

    always #5 clk = ~clk;

    fault_pattern_sequencer dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_seed(seed),
        .i_num_patterns(num), .i_settle_cycles(settle), .o_mut_in(mut_in),
        .i_mut_out(mut_out), .o_sample_valid(sample_valid), .o_busy(busy),
        .o_done(done), .o_signature(signature), .o_pattern_cnt(pattern_cnt)
    );

    // MUT stand-in: loopback, constant 1, or a 16x16 multiply
    always_comb begin
        case (mut_sel)
            0:       mut_out = mut_in;
            1:       mut_out = 32'h1;
            default: mut_out = mut_in[31:16] * mut_in[15:0];
        endcase
    end

    function automatic logic [31:0] mutf(input logic [31:0] p);
        case (mut_sel)
            0:       return p;
            1:       return 32'h1;
            default: return p[31:16] * p[15:0];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One complete run; glitch>0 pulses start with a fresh seed in that cycle of the run.
    task automatic run(input bit m, input logic [31:0] sd, input int n, input int s, input int glitch);
        logic [31:0] p, sg;
        int          tot, k, ph;
        pats.delete(); sigs.delete();
        p  = (m && sd == 0) ? 32'h1 : sd;
        sg = '0;
        sigs.push_back(sg);
        for (int j = 0; j < n; j++) begin
            pats.push_back(p);
            sg = {sg[30:0], 1'b0} ^ (sg[31] ? MISR : 32'h0) ^ mutf(p);
            sigs.push_back(sg);
            p = m ? ((p >> 1) ^ (p[0] ? LFSR : 32'h0)) : p + 32'h1;
        end
        tot = (s + 2) * n + 1;

        @(negedge clk);
        start = 1'b1; mode = m; seed = sd; num = 33'(n); settle = 16'(s);
        for (int t = 1; t <= tot; t++) begin
            @(negedge clk);
            if (t == 1) begin
                mode = $urandom_range(0, 1); seed = $urandom;
                num = {1'b0, $urandom}; settle = 16'($urandom);
            end
            k  = (t - 1) / (s + 2);
            ph = (t - 1) % (s + 2);
            chk("mut_in", mut_in, (n == 0) ? last_mut : pats[(k < n) ? k : n - 1]);
            chk("sample_valid", sample_valid, (t < tot && ph == s + 1) ? 1 : 0);
            chk("busy", busy, (t < tot) ? 1 : 0);
            chk("done", done, (t == tot) ? 1 : 0);
            chk("pattern_cnt", pattern_cnt, k);
            chk("signature", signature, sigs[k]);
            start = (t == glitch);
        end
        if (n > 0) last_mut = pats[n - 1];
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_sig", signature, sigs[n]);
        chk("post_mut", mut_in, last_mut);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0; num = '0; settle = '0;
        repeat (3) @(negedge clk);
        chk("rst_mut_in", mut_in, 0);
        chk("rst_sig", signature, 0);
        chk("rst_cnt", pattern_cnt, 0);
        chk("rst_sv", sample_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        mut_sel = 0;
        run(1'b0, 32'h0, 3, 2, 0);
        chk("loop_sig", signature, 32'h0);
        chk("loop_cnt", pattern_cnt, 3);
        run(1'b1, 32'h0, 3, 0, 0);
        chk("lfsr_last", mut_in, 32'hC0300002);
        mut_sel = 1;
        run(1'b0, 32'hFFFFFFFF, 2, 0, 0);
        chk("wrap_sig", signature, 32'h3);
        chk("wrap_mut", mut_in, 32'h0);
        run(1'b0, $urandom, 0, 3, 0);
        chk("zero_sig", signature, 32'h0);

        mut_sel = 2;
        run(1'b0, 32'h1234_5678, 4, 1, 5);
        run(1'b1, 32'hDEAD_BEEF, 3, 1, 0);

        // Reset during the second SETTLE of a five-pattern run
        @(negedge clk);
        start = 1'b1; mode = 1'b0; seed = 32'h10; num = 33'd5; settle = 16'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy", busy, 1);
        chk("mid_mut", mut_in, 32'h11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_mut", mut_in, 0);
        chk("abort_sig", signature, 0);
        chk("abort_cnt", pattern_cnt, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sv", sample_valid, 0);
        last_mut = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("idle_done", done, 0);
        end

        for (int r = 0; r < 25; r++) begin
            bit          rm;
            logic [31:0] rs;
            int          rn, rsl, rg;
            mut_sel = $urandom_range(0, 2);
            rm  = $urandom_range(0, 1);
            rs  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            rn  = $urandom_range(0, 6);
            rsl = $urandom_range(0, 3);
            rg  = ($urandom_range(0, 1) == 1 && rn > 1) ? $urandom_range(2, (rsl + 2) * rn) : 0;
            run(rm, rs, rn, rsl, rg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
